// File: rtl/dsp_chk_pkg.sv
// Shared types and the golden-product model for the DSP result checker.
package dsp_chk_pkg;

  localparam int unsigned OP_A_W = 9;
  localparam int unsigned OP_B_W = 9;
  localparam int unsigned PROD_W = OP_A_W + OP_B_W;

  localparam logic [1:0] MODE_FULL_U = 2'd0;
  localparam logic [1:0] MODE_DUAL   = 2'd1;
  localparam logic [1:0] MODE_FULL_S = 2'd2;
  localparam logic [1:0] MODE_RSVD   = 2'd3;

  typedef struct packed {
    logic              skip;
    logic [1:0]        mode;
    logic [PROD_W-1:0] exp;
  } chk_entry_t;

  localparam int unsigned ENTRY_W = $bits(chk_entry_t);

  // Expected DSP output for one issue; lane split is fixed for 9x9 operands.
  function automatic logic [PROD_W-1:0] golden(input logic [1:0]        mode,
                                               input logic [OP_A_W-1:0] a,
                                               input logic [OP_B_W-1:0] b);
    logic [PROD_W-1:0] p;
    p = '0;
    case (mode)
      MODE_FULL_U: p = {{OP_B_W{1'b0}}, a} * {{OP_A_W{1'b0}}, b};
      MODE_DUAL: begin
        p[9:0]   = {5'b0, a[4:0]} * {5'b0, b[4:0]};
        p[17:10] = {4'b0, a[8:5]} * {4'b0, b[8:5]};
      end
      // Low PROD_W bits of a product of sign-extended operands equal the signed product.
      MODE_FULL_S: p = {{OP_B_W{a[OP_A_W-1]}}, a} * {{OP_A_W{b[OP_B_W-1]}}, b};
      default:     p = '0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/dsp_chk_fifo.sv
// Expected-value queue: registered storage, head read combinationally.
module dsp_chk_fifo #(
  parameter int unsigned WIDTH = 21,
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr_q, rptr_q;

  // Storage write; a push while full is only issued alongside a pop, so the slot is free.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q[AW-1:0]] <= wdata;
  end

  // Pointer update; clear wins over push and pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clear) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  assign rdata = mem[rptr_q[AW-1:0]];
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

endmodule

// File: rtl/dsp_result_checker.sv
// Checks in-order DSP results against golden products captured at issue time.
module dsp_result_checker
  import dsp_chk_pkg::*;
#(
  parameter int unsigned N     = 9,
  parameter int unsigned M     = 9,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CW    = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  input  logic           issue_valid,
  input  logic [1:0]     issue_mode,
  input  logic [N-1:0]   issue_a,
  input  logic [M-1:0]   issue_b,
  output logic           issue_ready,
  input  logic           res_valid,
  input  logic [N+M-1:0] res_data,
  output logic           pass_pulse,
  output logic           fail_pulse,
  output logic [CW-1:0]  chk_count,
  output logic [CW-1:0]  err_count,
  output logic           overflow,
  output logic           underflow,
  output logic           busy
);

  logic       full, empty, push_en, pop_en;
  chk_entry_t wentry, head;
  logic [ENTRY_W-1:0] wdata, rdata;

  logic          pass_q, fail_q, ovf_q, unf_q;
  logic [CW-1:0] chk_q, err_q;

  // Pop never waits on push; a push while full is accepted only when a pop frees a slot.
  assign pop_en  = res_valid && !empty;
  assign push_en = issue_valid && (!full || pop_en);

  // Golden value captured at issue.
  always_comb begin
    wentry      = '0;
    wentry.skip = (issue_mode == MODE_RSVD);
    wentry.mode = issue_mode;
    wentry.exp  = golden(issue_mode, issue_a, issue_b);
  end

  assign wdata = wentry;
  assign head  = chk_entry_t'(rdata);

  dsp_chk_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .push  (push_en),
    .pop   (pop_en),
    .wdata (wdata),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  // Verdict pulses, saturating counters and sticky flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      chk_q  <= '0;
      err_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else if (clear) begin
      pass_q <= 1'b0;
      fail_q <= 1'b0;
      chk_q  <= '0;
      err_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
    end else begin
      pass_q <= pop_en && !head.skip && (head.exp == res_data);
      fail_q <= pop_en && !head.skip && (head.exp != res_data);
      if (pop_en && (chk_q != '1)) chk_q <= chk_q + CW'(1);
      if (pop_en && !head.skip && (head.exp != res_data) && (err_q != '1)) err_q <= err_q + CW'(1);
      if (issue_valid && full && !pop_en) ovf_q <= 1'b1;
      if (res_valid && empty) unf_q <= 1'b1;
    end
  end

  assign issue_ready = !full;
  assign busy        = !empty;
  assign pass_pulse  = pass_q;
  assign fail_pulse  = fail_q;
  assign chk_count   = chk_q;
  assign err_count   = err_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;

endmodule

// File: tb/tb_dsp_result_checker.sv
// Bench for dsp_result_checker: directed table, corner sequences, random vs queue model.
module tb_dsp_result_checker;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 10;
  localparam int          CMAX  = (1 << CW) - 1;

  logic          clk, rst_n, clear, issue_valid, issue_ready, res_valid;
  logic [1:0]    issue_mode;
  logic [8:0]    issue_a, issue_b;
  logic [17:0]   res_data;
  logic          pass_pulse, fail_pulse, overflow, underflow, busy;
  logic [CW-1:0] chk_count, err_count;

  dsp_result_checker #(
    .N     (9),
    .M     (9),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear),
    .issue_valid (issue_valid),
    .issue_mode  (issue_mode),
    .issue_a     (issue_a),
    .issue_b     (issue_b),
    .issue_ready (issue_ready),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .pass_pulse  (pass_pulse),
    .fail_pulse  (fail_pulse),
    .chk_count   (chk_count),
    .err_count   (err_count),
    .overflow    (overflow),
    .underflow   (underflow),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic        skip;
    logic [17:0] exp;
  } mentry_t;

  mentry_t m_q[$];
  logic    m_pass, m_fail, m_ovf, m_unf;
  int      m_chk, m_err;

  typedef struct {
    logic [1:0]  mode;
    logic [8:0]  a;
    logic [8:0]  b;
    logic [17:0] res;
    logic        exp_pass;
    logic        exp_fail;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference product from plain integer arithmetic.
  function automatic logic [17:0] ref_golden(input int mode, input int a, input int b);
    int sa, sb, p;
    logic [31:0] t;
    case (mode)
      0: p = a * b;
      1: p = (a % 32) * (b % 32) + ((a / 32) * (b / 32)) * 1024;
      2: begin
        sa = (a >= 256) ? a - 512 : a;
        sb = (b >= 256) ? b - 512 : b;
        p  = sa * sb;
      end
      default: p = 0;
    endcase
    t = p;
    return t[17:0];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_pass = 0; m_fail = 0; m_ovf = 0; m_unf = 0;
    m_chk = 0; m_err = 0;
  endtask

  task automatic cmp_all();
    chk("pass_pulse", pass_pulse, m_pass);
    chk("fail_pulse", fail_pulse, m_fail);
    chk("chk_count", chk_count, m_chk);
    chk("err_count", err_count, m_err);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_unf);
    chk("busy", busy, m_q.size() != 0);
    chk("issue_ready", issue_ready, m_q.size() < DEPTH);
  endtask

  // One clock: drive, check combinational ready, advance model, compare after the edge.
  task automatic cyc(input logic clr, input logic iv, input logic [1:0] md, input logic [8:0] a,
                     input logic [8:0] b, input logic rv, input logic [17:0] rd);
    logic    pop, push, was_full, was_empty;
    mentry_t h;
    @(negedge clk);
    clear = clr; issue_valid = iv; issue_mode = md; issue_a = a; issue_b = b;
    res_valid = rv; res_data = rd;
    #1;
    chk("issue_ready_pre", issue_ready, m_q.size() < DEPTH);
    if (clr) begin
      model_reset();
    end else begin
      was_full  = (m_q.size() == DEPTH);
      was_empty = (m_q.size() == 0);
      pop  = rv && !was_empty;
      push = iv && (!was_full || pop);
      m_pass = 0; m_fail = 0;
      if (pop) begin
        h = m_q.pop_front();
        if (m_chk < CMAX) m_chk++;
        if (!h.skip) begin
          if (h.exp == rd) m_pass = 1;
          else begin
            m_fail = 1;
            if (m_err < CMAX) m_err++;
          end
        end
      end
      if (iv && was_full && !pop) m_ovf = 1;
      if (rv && was_empty) m_unf = 1;
      if (push) m_q.push_back('{skip: (md == 2'd3), exp: ref_golden(md, a, b)});
    end
    @(posedge clk);
    #1;
    cmp_all();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_clear();
    cyc(1, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    logic [17:0] rd;
    rst_n = 0; clear = 0; issue_valid = 0; issue_mode = 0; issue_a = 0; issue_b = 0;
    res_valid = 0; res_data = 0;
    model_reset();

    vecs[0] = '{2'd0, 9'd300,  9'd200,  18'd60000,   1'b1, 1'b0};
    vecs[1] = '{2'd1, 9'h067,  9'h0A9,  18'h03C3F,   1'b1, 1'b0};
    vecs[2] = '{2'd1, 9'h067,  9'h0A9,  18'h03C3E,   1'b0, 1'b1};
    vecs[3] = '{2'd2, 9'h1FF,  9'd2,    18'h3FFFE,   1'b1, 1'b0};
    vecs[4] = '{2'd2, 9'h1FF,  9'd2,    18'h003FE,   1'b0, 1'b1};
    vecs[5] = '{2'd3, 9'd17,   9'd5,    18'd85,      1'b0, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    cmp_all();
    @(negedge clk);
    rst_n = 1;

    // Directed table: issue, then return the result one cycle later.
    for (int i = 0; i < 6; i++) begin
      cyc(0, 1, vecs[i].mode, vecs[i].a, vecs[i].b, 0, 0);
      cyc(0, 0, 0, 0, 0, 1, vecs[i].res);
      chk("tbl_pass", pass_pulse, vecs[i].exp_pass);
      chk("tbl_fail", fail_pulse, vecs[i].exp_fail);
      if (i == 0) begin
        chk("tbl0_chk", chk_count, 1);
        chk("tbl0_err", err_count, 0);
      end
      if (i == 2) chk("tbl2_err", err_count, 1);
      idle();
      chk("pulse_one_cycle", pass_pulse | fail_pulse, 0);
    end
    chk("tbl_chk_total", chk_count, 6);
    chk("tbl_err_total", err_count, 2);

    // Fill past full with no results.
    do_clear();
    for (int i = 0; i < 9; i++) begin
      cyc(0, 1, 0, 9'(i + 1), 9'd3, 0, 0);
      if (i == 7) chk("ready_low_at_8", issue_ready, 0);
    end
    chk("overflow_after_9", overflow, 1);
    // Issue and result together while full: accepted, still full.
    cyc(0, 1, 0, 9'd10, 9'd10, 1, 18'd3);
    chk("full_swap_pass", pass_pulse, 1);
    chk("full_swap_ready", issue_ready, 0);
    chk("full_swap_depth", m_q.size(), 8);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0, 0, 1, m_q[0].exp);
    chk("drain_last_pass", pass_pulse, 1);
    chk("drain_empty", busy, 0);

    // Result against empty queue, same cycle as first issue.
    do_clear();
    cyc(0, 0, 0, 0, 0, 1, 18'd5);
    chk("unf_alone", underflow, 1);
    do_clear();
    cyc(0, 1, 0, 9'd7, 9'd6, 1, 18'd42);
    chk("unf_same_cycle", underflow, 1);
    chk("unf_no_pass", pass_pulse, 0);
    chk("unf_no_fail", fail_pulse, 0);
    chk("unf_busy", busy, 1);
    cyc(0, 0, 0, 0, 0, 1, 18'd42);
    chk("unf_entry_kept", pass_pulse, 1);

    // Reset between result and verdict.
    do_clear();
    cyc(0, 1, 0, 9'd3, 9'd4, 0, 0);
    cyc(0, 1, 0, 9'd3, 9'd4, 1, 18'd12);
    @(negedge clk);
    issue_valid = 0; res_valid = 1; res_data = 18'd12;
    #2 rst_n = 0;
    @(posedge clk);
    #1;
    model_reset();
    chk("rst_no_pass", pass_pulse, 0);
    chk("rst_chk", chk_count, 0);
    chk("rst_ready", issue_ready, 1);
    cmp_all();
    @(negedge clk);
    rst_n = 1; res_valid = 0;

    // Saturate err_count with 2^CW mismatches.
    cyc(0, 1, 0, 9'd1, 9'd1, 0, 0);
    for (int i = 0; i < (1 << CW) + 2; i++) cyc(0, 1, 0, 9'd1, 9'd1, 1, 18'd0);
    chk("err_saturated", err_count, CMAX);
    chk("chk_saturated", chk_count, CMAX);

    // Random traffic against the queue model.
    do_clear();
    for (int i = 0; i < 3000; i++) begin
      logic iv, rv, cl;
      iv = ($urandom_range(0, 99) < 55);
      rv = ($urandom_range(0, 99) < 50);
      cl = ($urandom_range(0, 299) == 0);
      rd = 18'($urandom);
      if (m_q.size() > 0 && $urandom_range(0, 2) != 0) rd = m_q[0].exp;
      cyc(cl, iv, 2'($urandom_range(0, 3)), 9'($urandom), 9'($urandom), rv, rd);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
